univ_shift_reg: RTL

//   Parametrised WIDTH-bit register with eight operating modes: hold, shift

---
 rtl/univ_shift_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register with saturating shift counter
//            and end-of-word done pulse, for serialising/deserialising words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_r,
    input  logic                       sin_l,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic                       sout_msb,
    output logic                       sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_PRE = CW'(WIDTH - 1);

    localparam logic [2:0] C_HOLD = 3'b000;
    localparam logic [2:0] C_SHL  = 3'b001;
    localparam logic [2:0] C_SHR  = 3'b010;
    localparam logic [2:0] C_ROL  = 3'b011;
    localparam logic [2:0] C_ROR  = 3'b100;
    localparam logic [2:0] C_LOAD = 3'b101;
    localparam logic [2:0] C_CLR  = 3'b110;
    localparam logic [2:0] C_INV  = 3'b111;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             done_q, done_d;
    logic             w_shift;

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        w_shift = 1'b0;
        if (en) begin
            case (mode)
                C_HOLD: data_d = data_q;
                C_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], sin_r};
                    w_shift = 1'b1;
                end
                C_SHR: begin
                    data_d  = {sin_l, data_q[WIDTH-1:1]};
                    w_shift = 1'b1;
                end
                C_ROL: begin
                    data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    w_shift = 1'b1;
                end
                C_ROR: begin
                    data_d  = {data_q[0], data_q[WIDTH-1:1]};
                    w_shift = 1'b1;
                end
                C_LOAD: begin
                    data_d = d;
                    cnt_d  = '0;
                end
                C_CLR: begin
                    data_d = '0;
                    cnt_d  = '0;
                end
                C_INV:   data_d = ~data_q;
                default: data_d = data_q;
            endcase
        end
        // Counter saturates at WIDTH; done marks only the edge that reaches it.
        if (w_shift && (cnt_q < C_CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == C_CNT_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q        = data_q;
    assign q_bar    = ~data_q;
    assign sout_msb = data_q[WIDTH-1];
    assign sout_lsb = data_q[0];
    assign cnt      = cnt_q;
    assign done     = done_q;

endmodule

`default_nettype wire
